i2s_array_scheduler: RTL and testbench
======================================

Name: i2s_array_scheduler

Overview:
- Collects stereo samples from N_PAIRS i2s_capture_24 instances (one per mic pair) and aligns them into one frame.
- Discards the mic start-up frames.
- Streams each aligned frame as 2*N_PAIRS words over one valid/ready interface to the downstream beamforming/processing path.
- Detects overrun and missing-pair (timeout) faults with sticky flags.

Parameters:
- N_PAIRS, 4, number of capture instances (2..8).
- DISCARD_FRAMES, 8, aligned frames dropped after enable (0 = none).
- TIMEOUT_CYC, 1024, clk_i cycles allowed from the first pair arriving to the last pair arriving in one frame.
- CH_W, $clog2(2*N_PAIRS), derived, channel index width.

Ports:
- clk_i  in  1  system clock (27 MHz).
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  run enable.
- clr_err_i  in  1  clears sticky error flags.
- ready_i  in  N_PAIRS  per-pair ready pulse from the capture instances.
- left_i  in  24*N_PAIRS  signed left samples; pair k at [24k+23:24k].
- right_i  in  24*N_PAIRS  signed right samples; same packing.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  downstream accept.
- m_data_o  out  24  signed sample.
- m_chan_o  out  CH_W  channel index (2k = left k, 2k+1 = right k).
- m_last_o  out  1  final word of frame.
- state_o  out  2  0 IDLE, 1 DISCARD, 2 COLLECT, 3 STREAM.
- overrun_o  out  1  sticky.
- timeout_o  out  1  sticky.

Behaviour:
- Reset (async, rst_ni low):
  - All outputs 0; state IDLE.
  - pending, bank, shadow, discard count and timeout counter all cleared.
  - Reset asserted mid-stream aborts the stream with no m_last_o.
- Bank:
  - In DISCARD/COLLECT/STREAM, ready_i[k] with pending[k]=0 latches left_i/right_i slice k into bank[k] and sets pending[k].
  - ready_i[k] with pending[k]=1: sample dropped (bank keeps old), overrun_o<=1.
  - In IDLE ready_i is ignored.
- Frame complete = all pending bits 1 (registered value).
- IDLE:
  - en_i=1 goes to DISCARD if DISCARD_FRAMES>0, else COLLECT.
  - pending cleared while in IDLE.
- DISCARD:
  - On frame complete: clear pending, increment count.
  - When count reaches DISCARD_FRAMES, go to COLLECT (count cleared).
- COLLECT:
  - On frame complete at cycle t: bank copied to shadow, pending cleared, state STREAM.
  - m_valid_o=1 at t+1 with chan 0.
- STREAM:
  - Words are emitted in order L0,R0,L1,R1,...; m_last_o=1 only on chan 2*N_PAIRS-1.
  - m_data_o/m_chan_o/m_last_o are held stable while m_valid_o=1 and m_ready_i=0.
  - On each handshake, chan advances; last handshake leaves STREAM.
  - Collection into bank continues during STREAM (double buffer).
- After last handshake:
  - en_i=0 goes to IDLE.
  - Otherwise go to COLLECT; a frame already complete is taken on the next cycle (one bubble cycle, valid low).
- en_i deassert:
  - In DISCARD/COLLECT: go to IDLE next cycle, partial frame discarded.
  - In STREAM: the current frame finishes, then IDLE.
- Same cycle as frame-complete copy:
  - ready_i[k] writes bank[k] and sets pending[k] as the first sample of the next frame.
  - The shadow takes the old bank contents.
- Timeout:
  - Counter runs while 0 < popcount(pending) < N_PAIRS (not in IDLE) and resets when pending=0.
  - On reaching TIMEOUT_CYC: timeout_o<=1, pending cleared, partial frame dropped, state unchanged.
  - If timeout and frame complete occur in the same cycle, completion wins.
- Sticky flags:
  - clr_err_i clears overrun_o/timeout_o.
  - If a new error event occurs in the same cycle as clr_err_i, set wins.
- Data is passed unmodified (no width change, sign preserved).

Test Plan:
- Reset mid-operation: N_PAIRS=4, DISCARD_FRAMES=2, en_i=1, all pairs pulse ready each 100 cycles with L=0x100000+k, R=0x200000+k.
  - First 2 frames produce no output.
  - Frame 3 gives 8 words chan 0..7, data 0x100000,0x200000,0x100001,..., m_last_o on chan 7 only.
  - Asserting rst_ni=0 during a word returns all outputs to 0 immediately.
- Backpressure: m_ready_i toggling 1/0 every cycle -> each word held stable while stalled; 8 handshakes per frame; no loss.
- Overrun: m_ready_i=0 for 3 frame periods.
  - overrun_o=1; the streamed frame is the first frame.
  - The second frame (already in bank) is next, with the third dropped.
  - clr_err_i then clears overrun_o to 0.
- Timeout: pair 3 never pulses ready, TIMEOUT_CYC=1024.
  - timeout_o=1 exactly 1024 cycles after the first pair's ready; pending cleared; no output.
- Skew/simultaneity: pairs arrive with 0..50-cycle skew; next-frame ready_i[0] coincides with the completion cycle.
  - Output frame is correct, and pair 0's new sample appears in the following frame.
- Enable drop: en_i=0 in the middle of STREAM -> frame completes with m_last_o, then state_o=0 and later ready_i is ignored.

Source files
------------

// File: rtl/i2s_array_scheduler.sv
// Gathers one stereo sample from each I2S capture pair into an aligned frame,
// then streams the frame as 2*N_PAIRS words over a valid/ready interface.
module i2s_array_scheduler #(
    parameter int unsigned  N_PAIRS        = 4,
    parameter int unsigned  DISCARD_FRAMES = 8,
    parameter int unsigned  TIMEOUT_CYC    = 1024,
    localparam int unsigned CH_W           = $clog2(2 * N_PAIRS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clr_err_i,
    input  logic [N_PAIRS-1:0]    ready_i,
    input  logic [24*N_PAIRS-1:0] left_i,
    input  logic [24*N_PAIRS-1:0] right_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [23:0]           m_data_o,
    output logic [CH_W-1:0]       m_chan_o,
    output logic                  m_last_o,
    output logic [1:0]            state_o,
    output logic                  overrun_o,
    output logic                  timeout_o
);
    localparam int unsigned     N_WORDS   = 2 * N_PAIRS;
    localparam int unsigned     DW        = $clog2(DISCARD_FRAMES + 2);
    localparam int unsigned     TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_WORDS - 1);
    localparam logic [DW-1:0]   DISC_LAST = DW'(DISCARD_FRAMES - 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISCARD = 2'd1,
        COLLECT = 2'd2,
        STREAM  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_PAIRS-1:0]  pending_q;
    logic [23:0]         bank_q   [N_WORDS];
    logic [23:0]         shadow_q [N_WORDS];
    logic [DW-1:0]       disc_q;
    logic [TW-1:0]       tmo_q;

    logic                active, frame_done, partial, hs;
    logic                take_frame, load_shadow, disc_inc, disc_clr, last_hs;
    logic                tmo_fire, clr_pend, overrun_ev;
    logic [N_PAIRS-1:0]  accept;
    logic [CH_W-1:0]     nxt_chan;

    assign active     = (state_q != IDLE);
    assign frame_done = &pending_q;
    assign partial    = (|pending_q) && !frame_done;
    assign hs         = m_valid_o && m_ready_i;
    assign nxt_chan   = m_chan_o + CH_W'(1);
    assign state_o    = state_q;

    // A cleared frame slot this cycle lets a same-cycle sample open the next frame.
    assign tmo_fire   = active && partial && (tmo_q == TMO_LAST);
    assign clr_pend   = take_frame || tmo_fire || !active;
    assign accept     = {N_PAIRS{active}} & ready_i & ({N_PAIRS{clr_pend}} | ~pending_q);
    assign overrun_ev = active && !clr_pend && (|(ready_i & pending_q));

    // Next-state and per-cycle control strobes.
    always_comb begin : p_fsm
        state_d     = state_q;
        take_frame  = 1'b0;
        load_shadow = 1'b0;
        disc_inc    = 1'b0;
        disc_clr    = 1'b0;
        last_hs     = 1'b0;
        case (state_q)
            IDLE: begin
                disc_clr = 1'b1;
                if (en_i) begin
                    state_d = (DISCARD_FRAMES > 0) ? DISCARD : COLLECT;
                end
            end
            DISCARD: begin
                if (!en_i) begin
                    state_d  = IDLE;
                    disc_clr = 1'b1;
                end else if (frame_done) begin
                    take_frame = 1'b1;
                    if (disc_q == DISC_LAST) begin
                        disc_clr = 1'b1;
                        state_d  = COLLECT;
                    end else begin
                        disc_inc = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (frame_done) begin
                    take_frame  = 1'b1;
                    load_shadow = 1'b1;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (hs && (m_chan_o == LAST_CH)) begin
                    last_hs = 1'b1;
                    state_d = en_i ? COLLECT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_state
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture bank plus shadow copy that feeds the output stream.
    always_ff @(posedge clk_i or negedge rst_ni) begin : p_bank
        if (!rst_ni) begin
            pending_q <= '0;
            bank_q    <= '{default: '0};
            shadow_q  <= '{default: '0};
        end else begin
            for (int k = 0; k < N_PAIRS; k++) begin
                if (accept[k]) begin
                    bank_q[2*k]   <= left_i[24*k +: 24];
                    bank_q[2*k+1] <= right_i[24*k +: 24];
                    pending_q[k]  <= 1'b1;
                end else if (clr_pend) begin
                    pending_q[k]  <= 1'b0;
                end
            end
            if (load_shadow) begin
                shadow_q <= bank_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_disc
        if (!rst_ni) begin
            disc_q <= '0;
        end else if (disc_clr) begin
            disc_q <= '0;
        end else if (disc_inc) begin
            disc_q <= disc_q + DW'(1);
        end
    end

    // Counts only while a frame is partially collected.
    always_ff @(posedge clk_i or negedge rst_ni) begin : p_tmo
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (!partial || clr_pend) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_stream
        if (!rst_ni) begin
            m_valid_o <= 1'b0;
            m_chan_o  <= '0;
            m_data_o  <= '0;
            m_last_o  <= 1'b0;
        end else if (load_shadow) begin
            m_valid_o <= 1'b1;
            m_chan_o  <= '0;
            m_data_o  <= bank_q[0];
            m_last_o  <= 1'b0;
        end else if (hs) begin
            if (last_hs) begin
                m_valid_o <= 1'b0;
                m_chan_o  <= '0;
                m_data_o  <= '0;
                m_last_o  <= 1'b0;
            end else begin
                m_chan_o  <= nxt_chan;
                m_data_o  <= shadow_q[nxt_chan];
                m_last_o  <= (nxt_chan == LAST_CH);
            end
        end
    end

    // Sticky error flags; a new event outranks a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin : p_flags
        if (!rst_ni) begin
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            overrun_o <= overrun_ev || (overrun_o && !clr_err_i);
            timeout_o <= tmo_fire || (timeout_o && !clr_err_i);
        end
    end

endmodule

// File: tb/tb_i2s_array_scheduler.sv
// Randomized bench for i2s_array_scheduler: frames are modelled as lists of
// words in L0,R0,L1,R1,... order and checked against the stream.
module tb_i2s_array_scheduler;
    localparam int unsigned NP   = 4;
    localparam int unsigned DISC = 2;
    localparam int unsigned TMO  = 1024;
    localparam int          PER  = 100;

    typedef struct packed {
        logic [23:0] d;
        logic [2:0]  ch;
        logic        last;
    } word_t;

    logic            clk_i = 1'b0;
    logic            rst_ni, en_i, clr_err_i, m_ready_i;
    logic [NP-1:0]   ready_i;
    logic [24*NP-1:0] left_i, right_i;
    logic            m_valid_o, m_last_o, overrun_o, timeout_o;
    logic [23:0]     m_data_o;
    logic [2:0]      m_chan_o;
    logic [1:0]      state_o;

    word_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    rdy_mode = 0;
    int    disc_left = 0;

    i2s_array_scheduler #(.N_PAIRS(NP), .DISCARD_FRAMES(DISC), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clr_err_i(clr_err_i),
        .ready_i(ready_i), .left_i(left_i), .right_i(right_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_chan_o(m_chan_o), .m_last_o(m_last_o), .state_o(state_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Downstream acceptance pattern.
    initial begin
        m_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = ~m_ready_i;
                2:       m_ready_i = 1'b0;
                default: m_ready_i = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Stream scoreboard and stall-stability monitor.
    word_t got, e, prev_word;
    logic  prev_stall = 1'b0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            got = {m_data_o, m_chan_o, m_last_o};
            if (prev_stall) begin
                n_cmp++;
                if (!m_valid_o || got !== prev_word) begin
                    n_err++;
                    $display("FAIL hold_stable got v=%b d=%h ch=%0d l=%b exp v=1 d=%h ch=%0d l=%b",
                             m_valid_o, got.d, got.ch, got.last, prev_word.d, prev_word.ch, prev_word.last);
                end
            end
            if (m_valid_o && m_ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word got d=%h ch=%0d l=%b exp none", got.d, got.ch, got.last);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL stream_word got d=%h ch=%0d l=%b exp d=%h ch=%0d l=%b",
                                 got.d, got.ch, got.last, e.d, e.ch, e.last);
                    end
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_word  = got;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic drive_cycle(input logic [NP-1:0] m, input logic [24*NP-1:0] l,
                               input logic [24*NP-1:0] r);
        @(posedge clk_i);
        #1;
        ready_i = m;
        left_i  = l;
        right_i = r;
    endtask

    task automatic push_frame(input logic [23:0] lw[NP], input logic [23:0] rw[NP]);
        for (int k = 0; k < NP; k++) begin
            exp_q.push_back({lw[k], 3'(2 * k), 1'b0});
            exp_q.push_back({rw[k], 3'(2 * k + 1), k == NP - 1});
        end
    endtask

    // One frame with each pair arriving once at a random offset; discarded frames are not expected.
    task automatic send_frame(input bit expect_it, input int skew_max, input bit pattern, input int period);
        int               off[NP];
        logic [23:0]      lw[NP], rw[NP];
        logic [NP-1:0]    m;
        logic [24*NP-1:0] lv, rv;
        for (int k = 0; k < NP; k++) begin
            off[k] = int'($urandom_range(skew_max, 0));
            lw[k]  = pattern ? 24'h100000 + 24'(k) : 24'($urandom());
            rw[k]  = pattern ? 24'h200000 + 24'(k) : 24'($urandom());
        end
        if (disc_left > 0) begin
            disc_left--;
        end else if (expect_it) begin
            push_frame(lw, rw);
        end
        for (int c = 0; c < period; c++) begin
            m = '0;
            for (int k = 0; k < NP; k++) begin
                lv[24*k +: 24] = 24'($urandom());
                rv[24*k +: 24] = 24'($urandom());
                if (off[k] == c) begin
                    m[k] = 1'b1;
                    lv[24*k +: 24] = lw[k];
                    rv[24*k +: 24] = rw[k];
                end
            end
            drive_cycle(m, lv, rv);
        end
        drive_cycle('0, lv, rv);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; en_i = 1'b0; clr_err_i = 1'b0;
        ready_i = '0; left_i = '0; right_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if ({m_valid_o, m_last_o, m_data_o, m_chan_o} !== '0) begin
            n_err++; $display("FAIL reset_stream got v=%b l=%b d=%h ch=%0d exp 0", m_valid_o, m_last_o, m_data_o, m_chan_o);
        end
        n_cmp++;
        if ({state_o, overrun_o, timeout_o} !== 4'b0) begin
            n_err++; $display("FAIL reset_state got st=%0d ov=%b to=%b exp 0", state_o, overrun_o, timeout_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_discard_and_midreset();
        bit found = 0;
        rdy_mode = 0;
        en_i = 1'b1;
        disc_left = DISC;
        @(negedge clk_i); @(negedge clk_i);
        n_cmp++;
        if (state_o !== 2'd1) begin n_err++; $display("FAIL enter_discard got %0d exp 1", state_o); end
        for (int f = 0; f < 3; f++) send_frame(1, 0, 1, PER);
        wait_drain();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL first_frame_drain got %0d left exp 0", exp_q.size()); end
        n_cmp++;
        if (state_o !== 2'd2) begin n_err++; $display("FAIL after_discard_state got %0d exp 2", state_o); end
        send_frame(1, 0, 1, 1);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk_i);
            found = m_valid_o && (m_chan_o == 3'd3);
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL midstream_reach got none exp chan 3"); end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({m_valid_o, m_last_o, m_data_o, m_chan_o, state_o} !== '0) begin
            n_err++; $display("FAIL midreset_outputs got v=%b l=%b d=%h ch=%0d st=%0d exp 0",
                              m_valid_o, m_last_o, m_data_o, m_chan_o, state_o);
        end
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        disc_left = DISC;
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        for (int f = 0; f < DISC + 4; f++) send_frame(1, 50, 0, PER);
        wait_drain();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL backpressure_drain got %0d left exp 0", exp_q.size()); end
        n_cmp++;
        if ({overrun_o, timeout_o} !== 2'b00) begin
            n_err++; $display("FAIL backpressure_flags got ov=%b to=%b exp 0", overrun_o, timeout_o);
        end
    endtask

    task automatic test_overrun();
        rdy_mode = 0;
        repeat (4) @(posedge clk_i);
        rdy_mode = 2;
        send_frame(1, 20, 0, PER);
        send_frame(1, 20, 0, PER);
        send_frame(0, 20, 0, PER);
        @(negedge clk_i);
        n_cmp++;
        if (overrun_o !== 1'b1) begin n_err++; $display("FAIL overrun_set got %b exp 1", overrun_o); end
        n_cmp++;
        if (state_o !== 2'd3) begin n_err++; $display("FAIL overrun_stall_state got %0d exp 3", state_o); end
        rdy_mode = 0;
        wait_drain();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL overrun_drain got %0d left exp 0", exp_q.size()); end
        @(posedge clk_i); #1; clr_err_i = 1'b1;
        @(posedge clk_i); #1; clr_err_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (overrun_o !== 1'b0) begin n_err++; $display("FAIL overrun_clear got %b exp 0", overrun_o); end
    endtask

    task automatic test_timeout();
        logic [24*NP-1:0] lv, rv;
        rdy_mode = 0;
        for (int k = 0; k < NP; k++) begin
            lv[24*k +: 24] = 24'($urandom());
            rv[24*k +: 24] = 24'($urandom());
        end
        drive_cycle(4'b0111, lv, rv);
        drive_cycle(4'b0000, lv, rv);
        repeat (TMO - 1) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (timeout_o !== 1'b0) begin n_err++; $display("FAIL timeout_early got %b exp 0", timeout_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (timeout_o !== 1'b1) begin n_err++; $display("FAIL timeout_set got %b exp 1", timeout_o); end
        n_cmp++;
        if (state_o !== 2'd2) begin n_err++; $display("FAIL timeout_state got %0d exp 2", state_o); end
        send_frame(1, 30, 0, PER);
        wait_drain();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL post_timeout_drain got %0d left exp 0", exp_q.size()); end
        n_cmp++;
        if (overrun_o !== 1'b0) begin n_err++; $display("FAIL post_timeout_overrun got %b exp 0", overrun_o); end
        @(posedge clk_i); #1; clr_err_i = 1'b1;
        @(posedge clk_i); #1; clr_err_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (timeout_o !== 1'b0) begin n_err++; $display("FAIL timeout_clear got %b exp 0", timeout_o); end
    endtask

    // Pair 0's next sample lands on the very cycle the previous frame is taken.
    task automatic test_skew();
        int               offx[NP] = '{0, 20, 50, 35};
        int               offy[NP] = '{51, 70, 80, 90};
        logic [23:0]      lx[NP], rx[NP], ly[NP], ry[NP];
        logic [NP-1:0]    m;
        logic [24*NP-1:0] lv, rv;
        rdy_mode = 0;
        for (int k = 0; k < NP; k++) begin
            lx[k] = 24'($urandom()); rx[k] = 24'($urandom());
            ly[k] = 24'($urandom()); ry[k] = 24'($urandom());
        end
        push_frame(lx, rx);
        push_frame(ly, ry);
        for (int c = 0; c < 110; c++) begin
            m = '0;
            for (int k = 0; k < NP; k++) begin
                lv[24*k +: 24] = 24'($urandom());
                rv[24*k +: 24] = 24'($urandom());
                if (offx[k] == c) begin m[k] = 1'b1; lv[24*k +: 24] = lx[k]; rv[24*k +: 24] = rx[k]; end
                if (offy[k] == c) begin m[k] = 1'b1; lv[24*k +: 24] = ly[k]; rv[24*k +: 24] = ry[k]; end
            end
            drive_cycle(m, lv, rv);
        end
        drive_cycle('0, lv, rv);
        wait_drain();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL skew_drain got %0d left exp 0", exp_q.size()); end
        n_cmp++;
        if (overrun_o !== 1'b0) begin n_err++; $display("FAIL skew_overrun got %b exp 0", overrun_o); end
    endtask

    task automatic test_enable_drop();
        bit found = 0;
        rdy_mode = 0;
        send_frame(1, 0, 0, 1);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk_i);
            found = m_valid_o && (m_chan_o == 3'd2);
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL drop_reach got none exp chan 2"); end
        #2 en_i = 1'b0;
        wait_drain();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL drop_drain got %0d left exp 0", exp_q.size()); end
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (state_o !== 2'd0) begin n_err++; $display("FAIL drop_idle got %0d exp 0", state_o); end
        send_frame(0, 10, 0, 20);
        repeat (5) @(negedge clk_i);
        n_cmp++;
        if ({state_o, m_valid_o, overrun_o} !== 4'b0) begin
            n_err++; $display("FAIL idle_ignores got st=%0d v=%b ov=%b exp 0", state_o, m_valid_o, overrun_o);
        end
    endtask

    task automatic test_random();
        @(posedge clk_i); #1;
        en_i = 1'b1;
        disc_left = DISC;
        rdy_mode = 3;
        for (int f = 0; f < DISC + 6; f++) send_frame(1, 50, 0, 150);
        wait_drain();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL random_drain got %0d left exp 0", exp_q.size()); end
        n_cmp++;
        if ({overrun_o, timeout_o} !== 2'b00) begin
            n_err++; $display("FAIL random_flags got ov=%b to=%b exp 0", overrun_o, timeout_o);
        end
    endtask

    initial begin
        test_reset();
        test_discard_and_midreset();
        test_backpressure();
        test_overrun();
        test_timeout();
        test_skew();
        test_enable_drop();
        test_random();
        repeat (5) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
